clock_time_dp: RTL and testbench
================================

Name: clock_time_dp

Overview:
- Time-keeping datapath for the clock mode of the clock/stopwatch design.
- Consumes the one-cycle adjust pulses (sec/min/hour) issued by the clock control unit.
- Free-runs a centisecond/second/minute/hour time-of-day counter from the system clock.
- Presents registered time fields to the FND/UART display path.

Parameters:
- F_COUNT, 100_000_000, system clock cycles per second; must be a multiple of 100.
- HOUR_INIT, 12, hour value loaded on reset (0..23).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- i_en  input  1  run enable; 1 = time advances, 0 = time frozen.
- i_btn_sec  input  1  one-cycle adjust pulse, +1 second.
- i_btn_min  input  1  one-cycle adjust pulse, +1 minute.
- i_btn_hour  input  1  one-cycle adjust pulse, +1 hour.
- o_msec  output  7  centiseconds, 0..99.
- o_sec  output  6  seconds, 0..59.
- o_min  output  6  minutes, 0..59.
- o_hour  output  5  hours, 0..23.

Behaviour:
- Reset (rst=0, asynchronous, no clock edge needed):
  - Tick divider = 0, o_msec = 0, o_sec = 0, o_min = 0, o_hour = HOUR_INIT.
  - All adjust pulses are ignored while rst=0.
- Tick divider:
  - Width $clog2(F_COUNT/100).
  - When i_en=1, counts 0..F_COUNT/100-1 and wraps to 0.
  - tick_100hz is internal, high for exactly the one cycle the divider equals F_COUNT/100-1 with i_en=1.
  - When i_en=0, the divider holds its value and no tick is generated.
- Cascade (all registered, one edge per update):
  - msec: on tick, 99 -> 0 with carry_sec, else +1.
  - sec: on carry_sec, 59 -> 0 with carry_min, else +1.
  - min: on carry_min, 59 -> 0 with carry_hour, else +1.
  - hour: on carry_hour, 23 -> 0, else +1.
  - Carries are combinational from the current field value plus the incoming carry, so a full 23:59:59.99 -> 00:00:00.00 rollover completes on a single edge.
- Adjust pulses:
  - i_btn_X at edge N: field X = (X+1) mod range, visible after edge N (latency 1).
  - An adjusted field never generates a carry: btn_sec at sec=59 gives sec=0 with min unchanged; btn_min at 59 gives 0; btn_hour at 23 gives 0.
  - Adjust pulses act regardless of i_en.
  - Adjust does not touch msec or the divider.
- Simultaneous events:
  - Adjust pulse and natural carry into the same field in the same cycle: the adjust wins, the field increments by exactly 1, and that natural carry is discarded. No carry propagates out of that field that cycle.
  - Pulses on different fields in the same cycle are independent: each field applies its own +1.
  - Example: btn_sec and btn_min together at 10:20:30 -> 10:21:31.
  - A natural carry into a field that is not being adjusted proceeds normally, even if another field is adjusted that cycle.
- A pulse held high for K cycles is treated as K increments; no edge detection is done here.
- Outputs are driven directly from registers; there is no combinational path from inputs to outputs.
- Reset asserted mid-count overrides everything at once.
- On the first edge after rst deasserts, counting restarts from the reset state.

Test Plan:
(Run with F_COUNT=1000, so the divider period is 10 cycles.)
1. Hold rst=0 for 3 cycles, then release with i_en=1 -> outputs 00:00:00.00 with hour=12 during reset; o_msec=1 after the 10th post-reset edge; o_msec=99 -> 0 with o_sec=1 after 1000 cycles.
2. From reset, apply 11 btn_hour, 59 btn_min and 59 btn_sec pulses (one per cycle), then run until o_msec=99 -> next tick gives o_hour=0, o_min=0, o_sec=0, o_msec=0 on the same edge.
3. With o_sec=59 and o_min=5, pulse btn_sec -> o_sec=0, o_min=5. With o_hour=23, pulse btn_hour -> o_hour=0.
4. With o_sec=10 and o_msec=99, pulse btn_sec on the same cycle as tick_100hz -> o_msec=0, o_sec=11 (not 12), o_min unchanged.
5. Drop i_en to 0 for 50 cycles mid-period -> o_msec and the divider are frozen. A btn_min pulse during the freeze still gives o_min+1. After i_en returns to 1, the divider resumes from its held value.
6. Assert rst=0 between clock edges at 12:34:56.78 -> outputs read 12:00:00.00 before the next clk edge. Release -> counting restarts from that state.

Source files
------------

// File: rtl/clock_time_dp.sv
// Clock-mode time-of-day datapath.
// A free-running divider produces a 100 Hz tick that drives a
// centisecond -> second -> minute -> hour cascade. One-cycle adjust pulses from
// the control unit bump the sec/min/hour fields by one without carrying.
// All outputs come straight from registers.
module clock_time_dp #(
    parameter int F_COUNT   = 100_000_000,  // clk cycles per second, multiple of 100
    parameter int HOUR_INIT = 12            // hour loaded on reset, 0..23
) (
    input  logic       clk,
    input  logic       rst,         // asynchronous, active low
    input  logic       i_en,
    input  logic       i_btn_sec,
    input  logic       i_btn_min,
    input  logic       i_btn_hour,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour
);

    localparam int               DIV_N    = F_COUNT / 100;
    localparam int               DIV_W    = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);

    localparam logic [6:0] MSEC_LAST = 7'd99;
    localparam logic [5:0] SEC_LAST  = 6'd59;
    localparam logic [5:0] MIN_LAST  = 6'd59;
    localparam logic [4:0] HOUR_LAST = 5'd23;

    logic [DIV_W-1:0] r_div;
    logic [6:0]       r_msec;
    logic [5:0]       r_sec;
    logic [5:0]       r_min;
    logic [4:0]       r_hour;

    logic [DIV_W-1:0] w_div_nxt;
    logic [6:0]       w_msec_nxt;
    logic [5:0]       w_sec_nxt;
    logic [5:0]       w_min_nxt;
    logic [4:0]       w_hour_nxt;

    logic w_tick;
    logic w_carry_sec;
    logic w_carry_min;
    logic w_carry_hour;
    logic w_inc_sec;
    logic w_inc_min;
    logic w_inc_hour;

    // The tick only exists while running; a frozen divider never fires.
    assign w_tick = i_en & (r_div == DIV_LAST);

    // Ripple carries are purely combinational so a full-day rollover lands on
    // one edge. An adjusted field swallows the carry that would leave it.
    assign w_carry_sec  = w_tick & (r_msec == MSEC_LAST);
    assign w_carry_min  = w_carry_sec & ~i_btn_sec & (r_sec == SEC_LAST);
    assign w_carry_hour = w_carry_min & ~i_btn_min & (r_min == MIN_LAST);

    // Adjust and incoming carry both mean "+1 once", so they simply OR.
    assign w_inc_sec  = i_btn_sec  | w_carry_sec;
    assign w_inc_min  = i_btn_min  | w_carry_min;
    assign w_inc_hour = i_btn_hour | w_carry_hour;

    // Next-state values for the divider and every time field.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch can be inferred.
        w_div_nxt  = r_div;
        w_msec_nxt = r_msec;
        w_sec_nxt  = r_sec;
        w_min_nxt  = r_min;
        w_hour_nxt = r_hour;

        if (i_en) begin
            w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        end
        if (w_tick) begin
            w_msec_nxt = (r_msec == MSEC_LAST) ? 7'd0 : r_msec + 7'd1;
        end
        if (w_inc_sec) begin
            w_sec_nxt = (r_sec == SEC_LAST) ? 6'd0 : r_sec + 6'd1;
        end
        if (w_inc_min) begin
            w_min_nxt = (r_min == MIN_LAST) ? 6'd0 : r_min + 6'd1;
        end
        if (w_inc_hour) begin
            w_hour_nxt = (r_hour == HOUR_LAST) ? 5'd0 : r_hour + 5'd1;
        end
    end

    // State register; reset forces the known time of day immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_msec <= 7'd0;
            r_sec  <= 6'd0;
            r_min  <= 6'd0;
            r_hour <= 5'(HOUR_INIT);
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, which is what the carry chain above assumes.
            r_div  <= w_div_nxt;
            r_msec <= w_msec_nxt;
            r_sec  <= w_sec_nxt;
            r_min  <= w_min_nxt;
            r_hour <= w_hour_nxt;
        end
    end

    assign o_msec = r_msec;
    assign o_sec  = r_sec;
    assign o_min  = r_min;
    assign o_hour = r_hour;

endmodule

// File: tb/tb_clock_time_dp.sv
// Self-checking bench for clock_time_dp with a 10-cycle tick period.
// A per-cycle reference model feeds a scoreboard queue, a vector table covers
// the adjust pulses, and hand-written sequences cover the rollover, the
// adjust-versus-carry collision, the freeze, and the asynchronous reset.
module tb_clock_time_dp;

    localparam int F_COUNT   = 1000;
    localparam int HOUR_INIT = 12;
    localparam int DIV_N     = F_COUNT / 100;

    typedef struct packed {
        logic [6:0] msec;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
    } tod_t;

    typedef struct {
        logic bs;
        logic bm;
        logic bh;
        tod_t exp;
    } vec_t;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       i_en       = 1'b0;
    logic       i_btn_sec  = 1'b0;
    logic       i_btn_min  = 1'b0;
    logic       i_btn_hour = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;

    int   n_checks = 0;
    int   n_fail   = 0;
    tod_t sb_q[$];

    // Reference model: index 0 msec, 1 sec, 2 min, 3 hour.
    int m_div;
    int m_f[4];
    int mods[4] = '{100, 60, 60, 24};

    clock_time_dp #(
        .F_COUNT  (F_COUNT),
        .HOUR_INIT(HOUR_INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .i_btn_sec (i_btn_sec),
        .i_btn_min (i_btn_min),
        .i_btn_hour(i_btn_hour),
        .o_msec    (o_msec),
        .o_sec     (o_sec),
        .o_min     (o_min),
        .o_hour    (o_hour)
    );

    always #5 clk = ~clk;

    function automatic tod_t mk(input int ms, input int s, input int m, input int h);
        tod_t t;
        t.msec = 7'(ms);
        t.sec  = 6'(s);
        t.min  = 6'(m);
        t.hour = 5'(h);
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tod(input string name, input tod_t exp);
        tod_t act;
        act = {o_msec, o_sec, o_min, o_hour};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d:%0d.%0d, expected %0d:%0d:%0d.%0d", name,
                     act.hour, act.min, act.sec, act.msec,
                     exp.hour, exp.min, exp.sec, exp.msec);
        end
    endtask

    task automatic model_reset();
        m_div = 0;
        m_f   = '{0, 0, 0, HOUR_INIT};
    endtask

    // Walks the fields low to high carrying a single "advance" token; an
    // adjusted field always advances and absorbs the token.
    task automatic model_step(input logic en, input logic bs, input logic bm, input logic bh);
        int btn[4];
        bit adv;
        if (!rst) begin
            model_reset();
        end else begin
            btn = '{0, int'(bs), int'(bm), int'(bh)};
            adv = en && (m_div == DIV_N - 1);
            if (en) m_div = (m_div + 1) % DIV_N;
            for (int i = 0; i < 4; i++) begin
                if (btn[i] != 0) begin
                    m_f[i] = (m_f[i] + 1) % mods[i];
                    adv    = 1'b0;
                end else if (adv) begin
                    adv    = (m_f[i] == mods[i] - 1);
                    m_f[i] = (m_f[i] + 1) % mods[i];
                end
            end
        end
    endtask

    // Drives one cycle of stimulus, predicts, then compares after the edge.
    task automatic cycle(input logic en, input logic bs, input logic bm, input logic bh);
        tod_t e;
        i_en       = en;
        i_btn_sec  = bs;
        i_btn_min  = bm;
        i_btn_hour = bh;
        model_step(en, bs, bm, bh);
        sb_q.push_back(mk(m_f[0], m_f[1], m_f[2], m_f[3]));
        @(posedge clk);
        #1;
        i_btn_sec  = 1'b0;
        i_btn_min  = 1'b0;
        i_btn_hour = 1'b0;
        e = sb_q.pop_front();
        check_tod("scoreboard", e);
    endtask

    task automatic hold_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   guard;
        int   frozen_ms;
        int   edges;

        tbl[0] = '{1'b1, 1'b0, 1'b0, mk(0, 1, 0, 12)};
        tbl[1] = '{1'b0, 1'b1, 1'b0, mk(0, 1, 1, 12)};
        tbl[2] = '{1'b0, 1'b0, 1'b1, mk(0, 1, 1, 13)};
        tbl[3] = '{1'b1, 1'b1, 1'b0, mk(0, 2, 2, 13)};
        tbl[4] = '{1'b1, 1'b1, 1'b1, mk(0, 3, 3, 14)};
        tbl[5] = '{1'b0, 1'b0, 1'b0, mk(0, 3, 3, 14)};
        tbl[6] = '{1'b0, 1'b1, 1'b1, mk(0, 3, 4, 15)};
        tbl[7] = '{1'b1, 1'b0, 1'b1, mk(0, 4, 4, 16)};

        model_reset();

        // 1: asynchronous reset state, first tick, first second.
        #2 rst = 1'b0;
        #1 check_tod("async reset at start", mk(0, 0, 0, 12));
        @(posedge clk);
        #1;
        hold_reset(3);
        check_tod("reset held 3 cycles", mk(0, 0, 0, 12));
        run(9);
        check("msec before 10th edge", int'(o_msec), 0);
        run(1);
        check_tod("first tick at 10th edge", mk(1, 0, 0, 12));
        run(989);
        check_tod("msec 99 at cycle 999", mk(99, 0, 0, 12));
        run(1);
        check_tod("first second at cycle 1000", mk(0, 1, 0, 12));

        // 2: set 23:59:59 by pulses, then full-day rollover on one edge.
        hold_reset(2);
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 59; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (o_msec != 7'd99 && guard < 2000) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        check_tod("just before day rollover", mk(99, 59, 59, 23));
        guard = 0;
        while (o_msec == 7'd99 && guard < 2 * DIV_N) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        check_tod("day rollover single edge", mk(0, 0, 0, 0));

        // Vector table: adjust pulses with time frozen.
        hold_reset(2);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, tbl[i].bs, tbl[i].bm, tbl[i].bh);
            check_tod($sformatf("adjust vector %0d", i), tbl[i].exp);
        end

        // 3: adjust at the field limit wraps without carrying.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 55; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_tod("sec 59 min 5", mk(0, 59, 5, 16));
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_tod("btn_sec at 59 no carry", mk(0, 0, 5, 16));
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("hour set to 23", int'(o_hour), 23);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_tod("btn_hour at 23 wraps", mk(0, 0, 5, 0));
        for (int i = 0; i < 54; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_tod("btn_min at 59 no carry", mk(0, 0, 0, 0));

        // 4: btn_sec on the same edge as the msec 99 -> 0 carry.
        hold_reset(2);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_tod("sec set to 10", mk(0, 10, 0, 12));
        guard = 0;
        while (!(m_f[0] == 99 && m_div == DIV_N - 1) && guard < 2000) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        check("reach collision point", guard, 999);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_tod("adjust wins over carry", mk(0, 11, 0, 12));

        // 5: freeze mid-period with an adjust during the freeze.
        guard = 0;
        while (m_div != 4 && guard < 2 * DIV_N) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        frozen_ms = m_f[0];
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, (i == 20), 1'b0);
        check("msec frozen", int'(o_msec), frozen_ms);
        check("btn_min during freeze", int'(o_min), 1);
        edges = 0;
        while (int'(o_msec) == frozen_ms && edges < 2 * DIV_N) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            edges++;
        end
        check("divider resumes from held value", edges, 6);

        // 6: reset asserted between edges at 12:34:56.78.
        hold_reset(2);
        for (int i = 0; i < 34; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 56; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run(780);
        check_tod("time before async reset", mk(78, 56, 34, 12));
        #2 rst = 1'b0;
        #1 check_tod("async reset mid-cycle", mk(0, 0, 0, 12));
        model_reset();
        @(posedge clk);
        #1;
        hold_reset(1);
        run(10);
        check_tod("restart after reset", mk(1, 0, 0, 12));

        check("scoreboard drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
